// File: rtl/timer_compare_irq_pkg.sv
// Shared register map and bit positions for the compare/interrupt timer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package timer_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_COMPARE = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;

    localparam int ST_PENDING = 0;
    localparam int ST_OVERRUN = 1;

endpackage

// File: rtl/timer_compare_irq_if.sv
// CPU-side register port plus interrupt request/acknowledge of the compare timer.
// Latency: reads return one cycle after rd_en; writes land on the wr_en edge.
// Backpressure: none; strobes are always accepted.
interface timer_compare_irq_if #(
    parameter int WIDTH = 32
);
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [1:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             irq;
    logic             irq_ack;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, irq_ack,
        input  rd_data, rd_valid, irq
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, irq_ack,
        output rd_data, rd_valid, irq
    );
endinterface

// File: rtl/timer_compare_irq_match.sv
// Edge-qualified compare: hit when enabled, count equals compare, and count moved.
// Latency: hit is combinational from count_in; prev_count is one cycle behind.
// Backpressure: none.
module timer_match_detect #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_compare,
    output logic             o_hit
);

    logic [WIDTH-1:0] r_prev_count;

    // Track the last sampled count regardless of EN so re-enabling on a
    // stalled counter does not count as movement.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_count <= '0;
        end else begin
            r_prev_count <= i_count;
        end
    end

    // A counter parked on COMPARE must fire only once, hence the change test.
    assign o_hit = i_en && (i_count == i_compare) && (i_count != r_prev_count);

endmodule

// File: rtl/timer_compare_irq.sv
// Compare timer: raises a level irq when the counter reaches COMPARE; one-shot or auto-reload.
// Latency: irq asserts the cycle after the hit edge; register reads return one cycle after rd_en.
// Backpressure: none; every write, read and acknowledge is taken on its strobe cycle.
module timer_compare_irq
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    count_in,
    timer_compare_irq_if.slave  bus
);

    logic             r_en;
    logic             r_periodic;
    logic [WIDTH-1:0] r_compare;
    logic [WIDTH-1:0] r_period;
    logic             r_pending;
    logic             r_overrun;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    logic             w_hit;
    logic             w_wr_ctrl;
    logic             w_wr_compare;
    logic             w_wr_period;
    logic             w_wr_status;
    logic             w_clr_pending;
    logic             w_clr_overrun;
    logic [WIDTH-1:0] w_rd_mux;

    timer_match_detect #(
        .WIDTH (WIDTH)
    ) u_match (
        .clk       (clk),
        .reset     (reset),
        .i_en      (r_en),
        .i_count   (count_in),
        .i_compare (r_compare),
        .o_hit     (w_hit)
    );

    assign w_wr_ctrl    = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
    assign w_wr_compare = bus.wr_en && (bus.wr_addr == ADDR_COMPARE);
    assign w_wr_period  = bus.wr_en && (bus.wr_addr == ADDR_PERIOD);
    assign w_wr_status  = bus.wr_en && (bus.wr_addr == ADDR_STATUS);

    assign w_clr_pending = bus.irq_ack || (w_wr_status && bus.wr_data[ST_PENDING]);
    assign w_clr_overrun = w_wr_status && bus.wr_data[ST_OVERRUN];

    // Control bits: a CPU write beats the one-shot self-disable on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en       <= bus.wr_data[CTRL_EN];
            r_periodic <= bus.wr_data[CTRL_PERIODIC];
        end else if (w_hit && !r_periodic) begin
            r_en       <= 1'b0;
        end
    end

    // COMPARE: CPU write beats the periodic reload; reload wraps modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_compare <= '0;
        end else if (w_wr_compare) begin
            r_compare <= bus.wr_data;
        end else if (w_hit && r_periodic) begin
            r_compare <= r_compare + r_period;
        end
    end

    // PERIOD is only ever changed by the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period <= '0;
        end else if (w_wr_period) begin
            r_period <= bus.wr_data;
        end
    end

    // Status flags: a hit always beats an acknowledge or write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_hit) begin
                r_pending <= 1'b1;
            end else if (w_clr_pending) begin
                r_pending <= 1'b0;
            end

            if (w_hit && r_pending) begin
                r_overrun <= 1'b1;
            end else if (w_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Read mux over pre-edge register contents; unused bits read zero.
    always_comb begin
        w_rd_mux = '0;
        case (bus.rd_addr)
            ADDR_CTRL: begin
                w_rd_mux[CTRL_EN]       = r_en;
                w_rd_mux[CTRL_PERIODIC] = r_periodic;
            end
            ADDR_COMPARE: w_rd_mux = r_compare;
            ADDR_PERIOD:  w_rd_mux = r_period;
            ADDR_STATUS: begin
                w_rd_mux[ST_PENDING] = r_pending;
                w_rd_mux[ST_OVERRUN] = r_overrun;
            end
            default: w_rd_mux = '0;
        endcase
    end

    // Registered read port: data holds between reads, valid pulses once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    // PENDING is a register, so the interrupt is already registered and
    // survives the one-shot EN clear.
    assign bus.irq      = r_pending;

endmodule

// File: tb/tb_timer_compare_irq.sv
module tb_timer_compare_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] count_in;

    timer_compare_irq_if #(.WIDTH(32)) bus ();

    timer_compare_irq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .count_in (count_in),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the register set as the CPU sees it.
    logic        m_en = 0, m_per = 0, m_pend = 0, m_ovr = 0, m_rdv = 0;
    logic [31:0] m_cmp = 0, m_period = 0, m_prev = 0, m_rd = 0;
    int          m_hits = 0;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_per, m_en};
            2'd1:    return m_cmp;
            2'd2:    return m_period;
            default: return {30'd0, m_ovr, m_pend};
        endcase
    endfunction

    always @(posedge clk) begin
        logic        hit, wc, wp, wq, ws;
        logic        n_en, n_per, n_pend, n_ovr;
        logic [31:0] n_cmp_v;
        if (reset) begin
            m_en = 0; m_per = 0; m_pend = 0; m_ovr = 0; m_rdv = 0;
            m_cmp = 0; m_period = 0; m_prev = 0; m_rd = 0;
        end else begin
            hit = m_en && (count_in == m_cmp) && (count_in != m_prev);
            if (hit) m_hits++;
            wc = bus.wr_en && bus.wr_addr == 2'd0;
            wq = bus.wr_en && bus.wr_addr == 2'd1;
            wp = bus.wr_en && bus.wr_addr == 2'd2;
            ws = bus.wr_en && bus.wr_addr == 2'd3;
            if (bus.rd_en) m_rd = m_read(bus.rd_addr);
            m_rdv = bus.rd_en;
            // A new interrupt while one is outstanding is an overrun.
            n_ovr  = (hit && m_pend) ? 1'b1 : ((ws && bus.wr_data[1]) ? 1'b0 : m_ovr);
            n_pend = hit ? 1'b1 : ((bus.irq_ack || (ws && bus.wr_data[0])) ? 1'b0 : m_pend);
            n_cmp_v = wq ? bus.wr_data : ((hit && m_per) ? m_cmp + m_period : m_cmp);
            n_en  = wc ? bus.wr_data[0] : ((hit && !m_per) ? 1'b0 : m_en);
            n_per = wc ? bus.wr_data[1] : m_per;
            if (wp) m_period = bus.wr_data;
            m_ovr = n_ovr; m_pend = n_pend; m_cmp = n_cmp_v; m_en = n_en; m_per = n_per;
            m_prev = count_in;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("irq", {31'd0, bus.irq}, {31'd0, m_pend});
        chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, m_rdv});
        chk("rd_data", bus.rd_data, m_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 0;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
        bus.rd_en = 1; bus.rd_addr = a;
        tick();
        bus.rd_en = 0;
        chk({nm, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
        chk(nm, bus.rd_data, exp);
    endtask

    task automatic step(input logic [31:0] v);
        count_in = v;
        tick();
    endtask

    task automatic ack();
        bus.irq_ack = 1;
        tick();
        bus.irq_ack = 0;
    endtask

    int h0;
    logic [31:0] cw;

    initial begin
        reset = 1; count_in = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rd_en = 0; bus.rd_addr = 0; bus.irq_ack = 0;
        tick(); tick();
        chk("reset_irq", {31'd0, bus.irq}, 32'd0);
        chk("reset_rdv", {31'd0, bus.rd_valid}, 32'd0);
        reset = 0;
        tick();

        // One-shot at 10.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        for (int v = 0; v <= 12; v++) begin
            step(v);
            chk($sformatf("oneshot_irq_%0d", v), {31'd0, bus.irq}, (v >= 10) ? 32'd1 : 32'd0);
        end
        rd_chk("oneshot_ctrl", 2'd0, 32'h0);
        rd_chk("oneshot_status", 2'd3, 32'h1);
        ack();
        chk("oneshot_ack_irq", {31'd0, bus.irq}, 32'd0);

        // Periodic every 5 with acknowledges.
        wr(2'd3, 32'h3);
        wr(2'd1, 32'd5);
        wr(2'd2, 32'd5);
        wr(2'd0, 32'h3);
        for (int v = 0; v <= 20; v++) begin
            step(v);
            chk($sformatf("periodic_irq_%0d", v), {31'd0, bus.irq},
                (v > 0 && v % 5 == 0) ? 32'd1 : 32'd0);
            if (bus.irq) ack();
        end
        rd_chk("periodic_compare", 2'd1, 32'd25);
        rd_chk("periodic_status", 2'd3, 32'h0);

        // Overrun across the 32-bit wrap.
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h3);
        wr(2'd1, 32'hFFFF_FFFE);
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h3);
        h0 = m_hits;
        cw = 32'hFFFF_FFFC;
        for (int k = 0; k < 8; k++) begin
            step(cw);
            cw = cw + 1;
        end
        chk("wrap_hits_model", m_hits - h0, 32'd2);
        rd_chk("wrap_compare", 2'd1, 32'h6);
        rd_chk("wrap_status", 2'd3, 32'h3);
        wr(2'd3, 32'h2);
        rd_chk("wrap_w1c_status", 2'd3, 32'h1);

        // Stalled counter parked on COMPARE, reload of zero keeps EN set.
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h3);
        wr(2'd1, 32'd7);
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h3);
        step(6);
        h0 = m_hits;
        for (int k = 0; k < 10; k++) step(7);
        chk("stall_hits_model", m_hits - h0, 32'd1);
        rd_chk("stall_status", 2'd3, 32'h1);
        rd_chk("stall_compare", 2'd1, 32'd7);

        // Hit coinciding with irq_ack while already pending.
        step(8);
        bus.irq_ack = 1;
        step(7);
        bus.irq_ack = 0;
        chk("hit_ack_irq", {31'd0, bus.irq}, 32'd1);
        rd_chk("hit_ack_status", 2'd3, 32'h3);

        // Reset mid-run with irq high.
        chk("pre_reset_irq", {31'd0, bus.irq}, 32'd1);
        reset = 1;
        tick();
        reset = 0;
        chk("midreset_irq", {31'd0, bus.irq}, 32'd0);
        chk("midreset_rdv", {31'd0, bus.rd_valid}, 32'd0);
        for (int a = 0; a < 4; a++) rd_chk($sformatf("midreset_reg%0d", a), a[1:0], 32'd0);

        // Randomized traffic against the model.
        count_in = 0;
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 6)      count_in = (count_in + 1) % 64;
            else if (r == 8) count_in = $urandom_range(0, 63);
            else if (r == 9) count_in = ($urandom_range(0, 3) == 0) ? $urandom : count_in;
            bus.wr_en   = ($urandom_range(0, 7) == 0);
            bus.wr_addr = 2'($urandom_range(0, 3));
            case (bus.wr_addr)
                2'd1:    bus.wr_data = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 63);
                2'd2:    bus.wr_data = $urandom_range(0, 20);
                default: bus.wr_data = $urandom;
            endcase
            bus.rd_en   = ($urandom_range(0, 2) == 0);
            bus.rd_addr = 2'($urandom_range(0, 3));
            bus.irq_ack = ($urandom_range(0, 5) == 0);
            reset       = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 0; bus.wr_en = 0; bus.rd_en = 0; bus.irq_ack = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
